// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the instruction/data sram-like port arbiter.
// State, owner and transfer-size constants plus the streak saturation helper.
package sram_like_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } arb_owner_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int STREAK_W = 4;
    localparam logic [STREAK_W-1:0] STREAK_ONE = 1;

    // Increment that sticks at the ceiling instead of wrapping.
    function automatic logic [STREAK_W-1:0] streak_step(
        input logic [STREAK_W-1:0] cur,
        input logic [STREAK_W-1:0] ceiling
    );
        if (cur >= ceiling) begin
            return ceiling;
        end
        return cur + STREAK_ONE;
    endfunction

endpackage

// File: rtl/sram_like_arbiter_streak.sv
// Priority decision between fetch and data requesters, with a saturating
// count of consecutive data grants that lets a waiting fetch break through.
module arb_streak_ctr
    import sram_like_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = 4
)
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       grant_en,
    input  logic       inst_req,
    input  logic       data_req,
    output logic       grant_valid,
    output arb_owner_t grant_owner
);

    localparam logic [STREAK_W-1:0] MAX_V = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] streak_reg;
    logic [STREAK_W-1:0] streak_next;
    logic                data_wins;

    // Data keeps priority until it has won MAX_STREAK times in a row over a waiting fetch.
    assign data_wins = data_req && (!inst_req || (streak_reg < MAX_V));

    always_comb begin
        grant_valid = grant_en && (data_wins || inst_req);
        grant_owner = data_wins ? OWN_DATA : OWN_INST;
        streak_next = streak_reg;
        if (grant_valid) begin
            if (data_wins && inst_req) begin
                streak_next = streak_step(streak_reg, MAX_V);
            end else begin
                streak_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            streak_reg <= '0;
        end else begin
            streak_reg <= streak_next;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between the fetch and data ports of the core,
// one outstanding transaction at a time, with registered request fields.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
)
(
    input  logic                clk,
    input  logic                resetn,

    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    output logic                mem_req,
    output logic                mem_wr,
    output logic [1:0]          mem_size,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t state_reg;
    arb_state_t state_next;
    arb_owner_t owner_reg;
    arb_owner_t owner_next;

    logic              mem_req_reg;
    logic              mem_wr_reg;
    logic [1:0]        mem_size_reg;
    logic [STRB_W-1:0] mem_wstrb_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    logic              grant_valid;
    arb_owner_t        grant_owner;
    logic              grant_wr;
    logic [1:0]        grant_size;
    logic [STRB_W-1:0] grant_wstrb;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;

    logic              addr_ok_fire;
    logic              data_ok_fire;
    logic              port_addr_ok [2];
    logic              port_data_ok [2];
    logic [DATA_W-1:0] port_rdata   [2];

    arb_streak_ctr #(
        .MAX_STREAK (MAX_STREAK)
    ) u_streak (
        .clk         (clk),
        .resetn      (resetn),
        .grant_en    (state_reg == IDLE),
        .inst_req    (inst_req),
        .data_req    (data_req),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Fetches are always full-word reads regardless of what the data port presents.
    always_comb begin
        grant_addr  = inst_addr;
        grant_wr    = 1'b0;
        grant_size  = SZ_WORD;
        grant_wstrb = '0;
        grant_wdata = '0;
        if (grant_owner == OWN_DATA) begin
            grant_addr  = data_addr;
            grant_wr    = data_wr;
            grant_size  = data_size;
            grant_wstrb = data_wstrb;
            grant_wdata = data_wdata;
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ADDR;
                    owner_next = grant_owner;
                end
            end
            ADDR: begin
                if (mem_addr_ok) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_data_ok) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            owner_reg     <= OWN_INST;
            mem_req_reg   <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_size_reg  <= 2'd0;
            mem_wstrb_reg <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            mem_req_reg <= (state_next == ADDR);
            if ((state_reg == IDLE) && grant_valid) begin
                mem_wr_reg    <= grant_wr;
                mem_size_reg  <= grant_size;
                mem_wstrb_reg <= grant_wstrb;
                mem_addr_reg  <= grant_addr;
                mem_wdata_reg <= grant_wdata;
            end
        end
    end

    // Handshakes only count in the state that expects them; anything else is dropped.
    assign addr_ok_fire = (state_reg == ADDR) && mem_addr_ok;
    assign data_ok_fire = (state_reg == WAIT) && mem_data_ok;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            localparam arb_owner_t PORT_ID = (gi == 0) ? OWN_INST : OWN_DATA;
            logic is_owner;
            assign is_owner          = (owner_reg == PORT_ID);
            assign port_addr_ok[gi]  = addr_ok_fire && is_owner;
            assign port_data_ok[gi]  = data_ok_fire && is_owner;
            assign port_rdata[gi]    = ((state_reg == WAIT) && is_owner) ? mem_rdata : '0;
        end
    endgenerate

    assign inst_addr_ok = port_addr_ok[OWN_INST];
    assign inst_data_ok = port_data_ok[OWN_INST];
    assign inst_rdata   = port_rdata[OWN_INST];
    assign data_addr_ok = port_addr_ok[OWN_DATA];
    assign data_data_ok = port_data_ok[OWN_DATA];
    assign data_rdata   = port_rdata[OWN_DATA];

    assign mem_req   = mem_req_reg;
    assign mem_wr    = mem_wr_reg;
    assign mem_size  = mem_size_reg;
    assign mem_wstrb = mem_wstrb_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Arbitrates between the CPU's instruction-fetch port and data port, which share one sram-like memory port (req / addr_ok / data_ok handshake) on the path to the cache/AXI bridge.
- Allows one outstanding transaction at a time.
- Data port has priority; an anti-starvation counter guarantees fetch progress.
- Sits between the mips core and the single memory interface below mycpu_top.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte strobe width is DATA_W/8.
- MAX_STREAK, 4, consecutive data grants allowed while a fetch waits; range 1..15.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  fetch request; held until inst_addr_ok
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch request accepted by memory
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  DATA_W  fetch data
- data_req  in  1  data request; held until data_addr_ok
- data_wr  in  1  1 = write
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  DATA_W/8  byte write strobes
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  write data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  read data valid / write done
- data_rdata  out  DATA_W  read data
- mem_req  out  1  shared-port request
- mem_wr  out  1  shared-port write
- mem_size  out  2  shared-port size
- mem_wstrb  out  DATA_W/8  shared-port strobes
- mem_addr  out  ADDR_W  shared-port address
- mem_wdata  out  DATA_W  shared-port write data
- mem_addr_ok  in  1  memory accepted request
- mem_data_ok  in  1  memory response
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, ADDR, WAIT. Owner register: INST or DATA. Streak counter: 4 bits.
- Reset (asynchronous, resetn=0):
  - state=IDLE, streak=0, owner=INST.
  - All mem_* registers = 0.
  - Every *_addr_ok and *_data_ok output = 0.
- IDLE arbitration (evaluated each cycle):
  - If data_req and (not inst_req or streak<MAX_STREAK): owner=DATA.
  - Else if inst_req: owner=INST.
  - Else stay in IDLE.
- On a grant: latch the owner's addr/wr/size/wstrb/wdata into mem_* registers and go to ADDR. Fetches are forced to wr=0, size=2, wstrb=0.
- mem_req is registered: it asserts exactly 1 cycle after the requester's req is sampled in IDLE. mem_req=1 only in ADDR.
- ADDR state:
  - When mem_addr_ok=1, pulse the owner's *_addr_ok in the same cycle (combinational from mem_addr_ok & state==ADDR).
  - Next state is WAIT; mem_req drops.
- WAIT state:
  - When mem_data_ok=1, pulse the owner's *_data_ok in the same cycle.
  - The owner's *_rdata = mem_rdata combinationally; the non-owner's rdata is 0.
  - Next state is IDLE.
- Minimum turnaround: IDLE→ADDR→WAIT→IDLE, so back-to-back grants are spaced at least 3 cycles apart.
- mem_addr_ok or mem_data_ok arriving in an unexpected state is ignored; no pulse is forwarded.
- mem_addr_ok and mem_data_ok in the same ADDR cycle: only addr_ok is honoured; data_ok is expected in WAIT.
- Streak update, at each grant:
  - DATA grant with inst_req=1: streak+1, saturating at MAX_STREAK.
  - INST grant, or DATA grant with inst_req=0: streak=0.
- Requesters must hold their req fields stable until addr_ok. Fields are latched at grant; later changes do not affect the issued transaction.
- Reset mid-transaction: the transaction is abandoned and no *_data_ok is produced. The memory side shares resetn.
- Outputs to the non-owner are always 0.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, ADDR=2'd1, WAIT=2'd2
  - owner encoding: OWN_INST=1'b0, OWN_DATA=1'b1
  - size constants: SZ_BYTE, SZ_HALF, SZ_WORD
- One natural sub-module: arb_streak_ctr (saturating counter plus the priority decision). The FSM and muxing stay in the top.

Test Plan:
- Single fetch: inst_req=1 with addr 0xBFC00000; memory gives addr_ok on the 1st ADDR cycle and data_ok 2 cycles later with 0x3C1D0000 → mem_req rises 1 cycle after req; inst_addr_ok pulses once; inst_data_ok pulses once with inst_rdata=0x3C1D0000; data_* stay 0.
- Simultaneous req: inst_req=data_req=1 in IDLE with streak=0, data write to 0x80001000, wstrb=4'b0011 → DATA granted first, with mem_wr=1, mem_wstrb=4'b0011; INST granted on the next IDLE.
- Starvation: inst_req and data_req held continuously, MAX_STREAK=4 → grant order D,D,D,D,I,D…; streak resets to 0 after the INST grant.
- Memory stall: mem_addr_ok held 0 for 10 cycles → mem_req stays 1 with stable mem_addr; no addr_ok is forwarded until mem_addr_ok=1.
- Spurious response: mem_data_ok=1 while in IDLE → no *_data_ok pulse; state unchanged.
- Reset mid-operation: resetn=0 in WAIT → all outputs 0 immediately; after release, state=IDLE and a new inst_req is served normally.
